full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_if.sv | 23 ++
 rtl/full_adder.sv | 62 ++++++
 tb/tb_full_adder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder: in_valid/A/B/Cin in, out_valid/Sum/Cout out.
// There is no ready signal. A result is accepted on every edge where in_valid=1, and out_valid marks a fresh Sum/Cout.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output in_valid, A, B, Cin,
    input  out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output out_valid, Sum, Cout
  );
endinterface

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: {Cout, Sum} = A + B + Cin.
// Results are registered with 1-cycle latency by default; defining FULL_ADDER_COMB_EN makes the outputs purely combinational.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  full_adder_if.slave bus
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_sum[i]       = bus.A[i] ^ bus.B[i] ^ w_carry[i];
    assign w_carry[i + 1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & w_carry[i]) |
                            (bus.B[i] & w_carry[i]);
  end

`ifdef FULL_ADDER_COMB_EN
  assign bus.Sum       = w_sum;
  assign bus.Cout      = w_carry[WIDTH];
  assign bus.out_valid = bus.in_valid;
`else
  logic [1:0]       r_rst_sync;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  // Reset asserts asynchronously. Release is delayed two edges so capture starts cleanly on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else if (!r_rst_sync[1]) begin
      r_valid <= 1'b0;
    end else if (bus.in_valid) begin
      r_sum   <= w_sum;
      r_cout  <= w_carry[WIDTH];
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.Sum       = r_sum;
  assign bus.Cout      = r_cout;
  assign bus.out_valid = r_valid;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 instance and a WIDTH=8 instance share the clock and reset.
module tb_full_adder;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Truth table in A,B,Cin order, with the expected sum and carry for each row.
  localparam logic [2:0] VEC   [8] = '{3'b000, 3'b100, 3'b010, 3'b110,
                                       3'b001, 3'b101, 3'b011, 3'b111};
  localparam logic       EXP_S [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic       EXP_C [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FULL_ADDER_COMB_EN
  task automatic test_comb();
    bus1.in_valid = 1'b1; bus1.A = 1'b1; bus1.B = 1'b0; bus1.Cin = 1'b1;
    bus8.in_valid = 1'b1; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.Cin = 1'b1;
    #1;
    n_total++;
    if (bus1.Sum !== 1'b0) $display("FAIL comb_sum: got %b expected 0", bus1.Sum);
    else n_pass++;
    n_total++;
    if (bus1.Cout !== 1'b1) $display("FAIL comb_cout: got %b expected 1", bus1.Cout);
    else n_pass++;
    n_total++;
    if (bus1.out_valid !== 1'b1) $display("FAIL comb_valid: got %b expected 1", bus1.out_valid);
    else n_pass++;
    n_total++;
    if ({bus8.Cout, bus8.Sum} !== 9'h1FF)
      $display("FAIL comb_w8: got %h expected 1ff", {bus8.Cout, bus8.Sum});
    else n_pass++;
  endtask
`else
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus1.out_valid !== 1'b0 || bus1.Sum !== 1'b0 || bus1.Cout !== 1'b0)
      $display("FAIL reset_w1: got v=%b s=%b c=%b expected all 0",
               bus1.out_valid, bus1.Sum, bus1.Cout);
    else n_pass++;
    n_total++;
    if (bus8.out_valid !== 1'b0 || bus8.Sum !== 8'h00 || bus8.Cout !== 1'b0)
      $display("FAIL reset_w8: got v=%b s=%h c=%b expected all 0",
               bus8.out_valid, bus8.Sum, bus8.Cout);
    else n_pass++;
    release_reset();
    n_total++;
    if (bus1.out_valid !== 1'b0)
      $display("FAIL reset_idle_valid: got %b expected 0", bus1.out_valid);
    else n_pass++;
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus1.in_valid = 1'b1;
      {bus1.A, bus1.B, bus1.Cin} = VEC[i];
      @(posedge clk);
      #1;
      n_total++;
      if (bus1.out_valid !== 1'b1)
        $display("FAIL tt_valid[%0d]: got %b expected 1", i, bus1.out_valid);
      else n_pass++;
      n_total++;
      if (bus1.Sum !== EXP_S[i])
        $display("FAIL tt_sum[%0d]: got %b expected %b", i, bus1.Sum, EXP_S[i]);
      else n_pass++;
      n_total++;
      if (bus1.Cout !== EXP_C[i])
        $display("FAIL tt_cout[%0d]: got %b expected %b", i, bus1.Cout, EXP_C[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cin_lsb();
    logic [3:0] cin_drive;
    cin_drive = 4'd10;
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.A = 1'b0; bus1.B = 1'b1; bus1.Cin = cin_drive[0];
    @(posedge clk);
    #1;
    n_total++;
    if (bus1.Sum !== 1'b1 || bus1.Cout !== 1'b0)
      $display("FAIL cin_lsb: got s=%b c=%b expected s=1 c=0", bus1.Sum, bus1.Cout);
    else n_pass++;
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] a_v [3];
    logic [7:0] b_v [3];
    logic       c_v [3];
    logic [8:0] e_v [3];
    a_v = '{8'hFF, 8'h5A, 8'hFF};
    b_v = '{8'h01, 8'h3C, 8'hFF};
    c_v = '{1'b0, 1'b1, 1'b1};
    e_v = '{9'h100, 9'h097, 9'h1FF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.A = a_v[i]; bus8.B = b_v[i]; bus8.Cin = c_v[i];
      @(posedge clk);
      #1;
      n_total++;
      if (bus8.out_valid !== 1'b1 || {bus8.Cout, bus8.Sum} !== e_v[i])
        $display("FAIL wide[%0d]: got v=%b %h expected v=1 %h",
                 i, bus8.out_valid, {bus8.Cout, bus8.Sum}, e_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.A   = (i == 2) ? 8'hxx : 8'(8'h11 * (i + 1));
      bus8.B   = (i == 2) ? 8'hzz : 8'(8'h22 + i);
      bus8.Cin = (i == 2) ? 1'bx : 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (bus8.out_valid !== 1'b0 || bus8.Sum !== 8'hFF || bus8.Cout !== 1'b1)
        $display("FAIL hold[%0d]: got v=%b s=%h c=%b expected v=0 s=ff c=1",
                 i, bus8.out_valid, bus8.Sum, bus8.Cout);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.A = 1'b1; bus1.B = 1'b1; bus1.Cin = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus1.out_valid !== 1'b1 || bus1.Sum !== 1'b1 || bus1.Cout !== 1'b1)
      $display("FAIL pre_reset: got v=%b s=%b c=%b expected 1 1 1",
               bus1.out_valid, bus1.Sum, bus1.Cout);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus1.out_valid !== 1'b0 || bus1.Sum !== 1'b0 || bus1.Cout !== 1'b0)
      $display("FAIL async_reset: got v=%b s=%b c=%b expected all 0",
               bus1.out_valid, bus1.Sum, bus1.Cout);
    else n_pass++;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    release_reset();
    n_total++;
    if (bus1.out_valid !== 1'b0 || bus1.Sum !== 1'b0 || bus1.Cout !== 1'b0)
      $display("FAIL no_stale: got v=%b s=%b c=%b expected all 0",
               bus1.out_valid, bus1.Sum, bus1.Cout);
    else n_pass++;
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.A = 1'b0; bus1.B = 1'b1; bus1.Cin = 1'b0;
    n_total++;
    if (bus1.out_valid !== 1'b0)
      $display("FAIL pre_edge_valid: got %b expected 0", bus1.out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus1.out_valid !== 1'b1 || bus1.Sum !== 1'b1 || bus1.Cout !== 1'b0)
      $display("FAIL post_reset: got v=%b s=%b c=%b expected 1 1 0",
               bus1.out_valid, bus1.Sum, bus1.Cout);
    else n_pass++;
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    bus1.in_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
`ifdef FULL_ADDER_COMB_EN
    test_comb();
`else
    test_reset();
    test_truth_table();
    test_cin_lsb();
    test_wide();
    test_hold();
    test_reset_mid();
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
